// File: rtl/morra_match_driver_if.sv
// Host/game-FSM signal bundle for the Morra match driver.
interface morra_match_driver_if #(
    parameter int unsigned CNT_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [3:0]       cfg_rounds;
    logic             abort;
    logic [1:0]       P1;
    logic [1:0]       P2;
    logic             START;
    logic [1:0]       ROUND;
    logic [1:0]       GAME;
    logic             match_done;
    logic [1:0]       match_result;
    logic [3:0]       rounds_played;
    logic [CNT_W-1:0] p1_wins;
    logic [CNT_W-1:0] p2_wins;
    logic [CNT_W-1:0] ties;
    logic             err;

    modport master (
        input  cfg_valid, cfg_rounds, abort, ROUND, GAME,
        output cfg_ready, P1, P2, START, match_done, match_result,
               rounds_played, p1_wins, p2_wins, ties, err
    );

    modport slave (
        output cfg_valid, cfg_rounds, abort, ROUND, GAME,
        input  cfg_ready, P1, P2, START, match_done, match_result,
               rounds_played, p1_wins, p2_wins, ties, err
    );
endinterface

// File: rtl/morra_match_driver.sv
// Self-playing stimulus source for the Morra game FSM: configures a match,
// plays LFSR-generated legal moves and accumulates match statistics.
module morra_match_driver #(
    parameter logic [7:0]  SEED1 = 8'hA5,
    parameter logic [7:0]  SEED2 = 8'h3C,
    parameter int unsigned CNT_W = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    morra_match_driver_if.master bus
);
    localparam int unsigned LFSR_W = 8;
    localparam int unsigned RP_W   = 5;
    localparam logic [LFSR_W-1:0] TAPS      = 8'hB8;
    localparam logic [LFSR_W-1:0] SEED1_EFF = (SEED1 == 8'h00) ? 8'h01 : SEED1;
    localparam logic [LFSR_W-1:0] SEED2_EFF = (SEED2 == 8'h00) ? 8'h01 : SEED2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        GAP   = 3'd2,
        PLAY  = 3'd3,
        EVAL  = 3'd4,
        DONE  = 3'd5
    } state_e;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {1'b0, l[LFSR_W-1:1]} ^ (l[0] ? TAPS : '0);
    endfunction

    function automatic logic [1:0] rotate(input logic [1:0] m);
        case (m)
            2'b01:   return 2'b10;
            2'b10:   return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    // A winner may not repeat the move that just won.
    function automatic logic [1:0] legal_move(input logic [LFSR_W-1:0] l,
                                              input logic won, input logic [1:0] last);
        logic [1:0] raw;
        raw = (l[1:0] == 2'b00) ? 2'b01 : l[1:0];
        return (won && raw == last) ? rotate(raw) : raw;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    state_e            state_q, state_d;
    logic [3:0]        cfg_q, cfg_d;
    logic [RP_W-1:0]   rp_q, rp_d;
    logic [3:0]        rp_out_q, rp_out_d;
    logic              err_q, err_d;
    logic [LFSR_W-1:0] lfsr1_q, lfsr1_d, lfsr2_q, lfsr2_d;
    logic [1:0]        mv1_q, mv1_d, mv2_q, mv2_d;
    logic [1:0]        last1_q, last1_d, last2_q, last2_d;
    logic              won1_q, won1_d, won2_q, won2_d;
    logic [1:0]        p1_q, p1_d, p2_q, p2_d;
    logic              start_q, start_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              done_q, done_d;
    logic [1:0]        result_q, result_d;
    logic [CNT_W-1:0]  w1_q, w1_d, w2_q, w2_d, tie_q, tie_d;

    logic [RP_W-1:0]   rp_inc;
    logic [RP_W-1:0]   limit;
    logic [1:0]        m1, m2;

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        rp_d      = rp_q;
        err_d     = err_q;
        lfsr1_d   = lfsr1_q;
        lfsr2_d   = lfsr2_q;
        mv1_d     = mv1_q;
        mv2_d     = mv2_q;
        last1_d   = last1_q;
        last2_d   = last2_q;
        won1_d    = won1_q;
        won2_d    = won2_q;
        p1_d      = 2'b00;
        p2_d      = 2'b00;
        start_d   = 1'b0;
        done_d    = 1'b0;
        result_d  = result_q;
        w1_d      = w1_q;
        w2_d      = w2_q;
        tie_d     = tie_q;
        m1        = 2'b00;
        m2        = 2'b00;
        rp_inc    = rp_q + RP_W'(bus.ROUND != 2'b00);
        limit     = RP_W'(4) + RP_W'(cfg_q);

        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cfg_valid && cfg_ready_q) begin
                        cfg_d   = bus.cfg_rounds;
                        rp_d    = '0;
                        err_d   = 1'b0;
                        state_d = SETUP;
                    end
                end
                SETUP: begin
                    won1_d  = 1'b0;
                    won2_d  = 1'b0;
                    state_d = GAP;
                end
                GAP:  state_d = PLAY;
                PLAY: state_d = EVAL;
                EVAL: begin
                    if (bus.ROUND != 2'b00) begin
                        rp_d    = rp_inc;
                        last1_d = mv1_q;
                        last2_d = mv2_q;
                        won1_d  = (bus.ROUND == 2'b01);
                        won2_d  = (bus.ROUND == 2'b10);
                    end
                    if (bus.GAME != 2'b00) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = bus.GAME;
                        case (bus.GAME)
                            2'b01:   w1_d  = sat_inc(w1_q);
                            2'b10:   w2_d  = sat_inc(w2_q);
                            default: tie_d = sat_inc(tie_q);
                        endcase
                    end else if (rp_d == limit) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = PLAY;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Pin values are registered, so they are derived from the next state.
        cfg_ready_d = (state_d == IDLE);
        if (state_d == SETUP) begin
            start_d = 1'b1;
            p1_d    = cfg_d[3:2];
            p2_d    = cfg_d[1:0];
        end
        if (state_d == PLAY) begin
            m1      = legal_move(lfsr1_q, won1_d, last1_d);
            m2      = legal_move(lfsr2_q, won2_d, last2_d);
            p1_d    = m1;
            p2_d    = m2;
            mv1_d   = m1;
            mv2_d   = m2;
            lfsr1_d = lfsr_next(lfsr1_q);
            lfsr2_d = lfsr_next(lfsr2_q);
        end
        rp_out_d = (rp_d > RP_W'(15)) ? 4'hF : rp_d[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cfg_q       <= '0;
            rp_q        <= '0;
            rp_out_q    <= '0;
            err_q       <= 1'b0;
            lfsr1_q     <= SEED1_EFF;
            lfsr2_q     <= SEED2_EFF;
            mv1_q       <= 2'b00;
            mv2_q       <= 2'b00;
            last1_q     <= 2'b00;
            last2_q     <= 2'b00;
            won1_q      <= 1'b0;
            won2_q      <= 1'b0;
            p1_q        <= 2'b00;
            p2_q        <= 2'b00;
            start_q     <= 1'b0;
            cfg_ready_q <= 1'b1;
            done_q      <= 1'b0;
            result_q    <= 2'b00;
            w1_q        <= '0;
            w2_q        <= '0;
            tie_q       <= '0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            rp_q        <= rp_d;
            rp_out_q    <= rp_out_d;
            err_q       <= err_d;
            lfsr1_q     <= lfsr1_d;
            lfsr2_q     <= lfsr2_d;
            mv1_q       <= mv1_d;
            mv2_q       <= mv2_d;
            last1_q     <= last1_d;
            last2_q     <= last2_d;
            won1_q      <= won1_d;
            won2_q      <= won2_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            start_q     <= start_d;
            cfg_ready_q <= cfg_ready_d;
            done_q      <= done_d;
            result_q    <= result_d;
            w1_q        <= w1_d;
            w2_q        <= w2_d;
            tie_q       <= tie_d;
        end
    end

    assign bus.cfg_ready     = cfg_ready_q;
    assign bus.P1            = p1_q;
    assign bus.P2            = p2_q;
    assign bus.START         = start_q;
    assign bus.match_done    = done_q;
    assign bus.match_result  = result_q;
    assign bus.rounds_played = rp_out_q;
    assign bus.p1_wins       = w1_q;
    assign bus.p2_wins       = w2_q;
    assign bus.ties          = tie_q;
    assign bus.err           = err_q;
endmodule

// File: tb/tb_morra_match_driver.sv
// Randomized scoreboard bench for morra_match_driver with a rule-level player model.
module tb_morra_match_driver;
    localparam int unsigned CNT_W = 8;
    localparam int CNT_MAX = 255;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    morra_match_driver_if #(.CNT_W(CNT_W)) bus ();

    morra_match_driver #(.SEED1(8'hA5), .SEED2(8'h3C), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct { int p1; int p2; } pair_t;
    typedef struct { int res; int rp; int w1; int w2; int t; } done_t;

    pair_t exp_setup[$];
    pair_t exp_mv[$];
    done_t exp_done[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model of the players and statistics.
    int l1, l2, cur1, cur2, last1, last2, rp, limit, mw1, mw2, mt;
    bit won1, won2;
    int seq_r[4] = '{2, 2, 3, 2};
    int seq_g[4] = '{0, 0, 0, 2};

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int step(input int l);
        return (l / 2) ^ ((l % 2) * 184);
    endfunction

    function automatic int pick(input int l, input bit won, input int last);
        int raw;
        raw = l % 4;
        if (raw == 0) raw = 1;
        if (won && raw == last) raw = raw % 3 + 1;
        return raw;
    endfunction

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic push_move();
        pair_t m;
        m.p1 = pick(l1, won1, last1);
        m.p2 = pick(l2, won2, last2);
        cur1 = m.p1;
        cur2 = m.p2;
        l1 = step(l1);
        l2 = step(l2);
        exp_mv.push_back(m);
    endtask

    task automatic model_reset();
        l1 = 8'hA5; l2 = 8'h3C;
        mw1 = 0; mw2 = 0; mt = 0;
        won1 = 0; won2 = 0; last1 = 0; last2 = 0; rp = 0;
        exp_setup.delete(); exp_mv.delete(); exp_done.delete();
    endtask

    // Monitor: pops expectations whenever the DUT presents START, a move or match_done.
    int  start_cyc, play_cyc;
    bit  first_play;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.START) begin
                if (exp_setup.size() == 0) check("unexpected_start", 1, 0);
                else begin
                    pair_t e;
                    e = exp_setup.pop_front();
                    check("setup_p1", int'(bus.P1), e.p1);
                    check("setup_p2", int'(bus.P2), e.p2);
                end
                start_cyc  = cyc;
                first_play = 1'b1;
            end else if (bus.P1 != 2'b00 || bus.P2 != 2'b00) begin
                if (exp_mv.size() == 0) check("unexpected_move", int'({bus.P1, bus.P2}), 0);
                else begin
                    pair_t e;
                    e = exp_mv.pop_front();
                    check("move_p1", int'(bus.P1), e.p1);
                    check("move_p2", int'(bus.P2), e.p2);
                end
                if (first_play) check("start_to_move", cyc - start_cyc, 2);
                else            check("move_cadence", cyc - play_cyc, 2);
                play_cyc   = cyc;
                first_play = 1'b0;
            end
            if (bus.match_done) begin
                if (exp_done.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    done_t e;
                    e = exp_done.pop_front();
                    check("match_result", int'(bus.match_result), e.res);
                    check("done_rounds", int'(bus.rounds_played), e.rp);
                    check("p1_wins", int'(bus.p1_wins), e.w1);
                    check("p2_wins", int'(bus.p2_wins), e.w2);
                    check("ties", int'(bus.ties), e.t);
                end
            end
        end
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.cfg_ready) begin ok = 1'b1; return; end
            @(negedge clk);
        end
        check("ready_timeout", 0, 1);
    endtask

    task automatic wait_play(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.START && (bus.P1 != 2'b00 || bus.P2 != 2'b00)) begin ok = 1'b1; return; end
        end
        check("play_timeout", 0, 1);
    endtask

    task automatic start_match(input logic [3:0] cfg, output bit ok);
        pair_t s;
        wait_ready(ok);
        if (!ok) return;
        bus.cfg_rounds = cfg;
        bus.cfg_valid  = 1'b1;
        s.p1 = int'(cfg[3:2]);
        s.p2 = int'(cfg[1:0]);
        exp_setup.push_back(s);
        won1 = 0; won2 = 0; rp = 0;
        limit = 4 + int'(cfg);
        push_move();
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        check("cfg_to_start", int'(bus.START), 1);
    endtask

    // Game-FSM stand-in: Moore result visible during the EVAL cycle.
    task automatic play_round(input int r, input int g, output int ended);
        done_t d;
        ended = 0;
        if (r != 0) begin
            rp++;
            last1 = cur1; last2 = cur2;
            won1 = (r == 1); won2 = (r == 2);
        end
        if (g != 0) begin
            if (g == 1) mw1 = sat(mw1);
            else if (g == 2) mw2 = sat(mw2);
            else mt = sat(mt);
            d.res = g; d.rp = (rp > 15) ? 15 : rp;
            d.w1 = mw1; d.w2 = mw2; d.t = mt;
            exp_done.push_back(d);
            ended = 1;
        end else if (rp == limit) begin
            ended = 2;
        end else begin
            push_move();
        end
        @(posedge clk); #1;
        bus.ROUND = 2'(r);
        bus.GAME  = 2'(g);
        @(posedge clk); #1;
        bus.ROUND = 2'b00;
        bus.GAME  = 2'b00;
    endtask

    // mode 0 random, 1 directed sequence, 2 instant P1 win, 3 P1-heavy, 4 endless draws
    task automatic run_match(input logic [3:0] cfg, input int mode);
        bit ok;
        int r, g, ended;
        start_match(cfg, ok);
        if (!ok) return;
        ended = 0;
        for (int idx = 0; idx < 200 && ended == 0; idx++) begin
            wait_play(ok);
            if (!ok) return;
            case (mode)
                0: begin
                    r = int'($urandom_range(0, 3));
                    g = (r != 0 && $urandom_range(0, 9) == 0) ? r : 0;
                end
                1: begin
                    r = (idx < 4) ? seq_r[idx] : 3;
                    g = (idx < 4) ? seq_g[idx] : 3;
                end
                2: begin r = 1; g = 1; end
                3: begin
                    r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 1;
                    g = 0;
                end
                default: begin r = 3; g = 0; end
            endcase
            play_round(r, g, ended);
        end
        @(negedge clk);
        if (ended == 1) begin
            check("ready_in_done", int'(bus.cfg_ready), 0);
            check("err_after_done", int'(bus.err), 0);
            @(negedge clk);
            check("ready_after_done", int'(bus.cfg_ready), 1);
        end else if (ended == 2) begin
            check("err_set", int'(bus.err), 1);
            check("ready_after_err", int'(bus.cfg_ready), 1);
            check("err_rounds", int'(bus.rounds_played), (rp > 15) ? 15 : rp);
            check("err_p1_wins", int'(bus.p1_wins), mw1);
            check("err_ties", int'(bus.ties), mt);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    initial begin
        bit ok;
        bus.cfg_valid = 1'b0; bus.cfg_rounds = 4'h0; bus.abort = 1'b0;
        bus.ROUND = 2'b00; bus.GAME = 2'b00;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_cfg_ready", int'(bus.cfg_ready), 1);
        check("rst_start", int'(bus.START), 0);
        check("rst_p1", int'(bus.P1), 0);
        check("rst_p2", int'(bus.P2), 0);
        check("rst_done", int'(bus.match_done), 0);
        check("rst_result", int'(bus.match_result), 0);
        check("rst_rounds", int'(bus.rounds_played), 0);
        check("rst_counters", int'(bus.p1_wins) + int'(bus.p2_wins) + int'(bus.ties), 0);
        check("rst_err", int'(bus.err), 0);

        run_match(4'd2, 1);
        run_match(4'b0110, 0);
        run_match(4'd0, 4);

        // Abort while a move is on the pins.
        start_match(4'd5, ok);
        if (ok) wait_play(ok);
        if (ok) begin
            bus.abort = 1'b1;
            @(negedge clk);
            bus.abort = 1'b0;
            check("abort_ready", int'(bus.cfg_ready), 1);
            check("abort_start", int'(bus.START), 0);
            check("abort_p", int'({bus.P1, bus.P2}), 0);
            check("abort_done", int'(bus.match_done), 0);
            check("abort_rounds", int'(bus.rounds_played), 0);
            check("abort_p1_wins", int'(bus.p1_wins), mw1);
            @(negedge clk);
        end

        for (int i = 0; i < 25; i++) run_match(4'($urandom_range(4, 11)), 3);
        for (int i = 0; i < 40; i++) run_match(4'($urandom_range(0, 15)), 0);

        while (mw1 < CNT_MAX) run_match(4'($urandom_range(0, 15)), 2);
        run_match(4'd3, 2);
        run_match(4'd3, 2);
        check("p1_wins_saturated", int'(bus.p1_wins), CNT_MAX);

        // Reset in the middle of a match.
        start_match(4'd5, ok);
        if (ok) wait_play(ok);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", int'(bus.cfg_ready), 1);
        check("midrst_p", int'({bus.P1, bus.P2}), 0);
        check("midrst_p1_wins", int'(bus.p1_wins), 0);
        check("midrst_rounds", int'(bus.rounds_played), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        run_match(4'd1, 0);

        repeat (3) @(negedge clk);
        check("pending_expectations", exp_setup.size() + exp_mv.size() + exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
